// File: rtl/program_counter_ext_if.sv
// Command/status bundle between the sequencer and the extended program counter.
// The master side drives the commands and the slave side returns the PC and the stack status.
interface program_counter_ext_if #(
    parameter int unsigned LOW_WIDTH   = 8,
    parameter int unsigned HIGH_WIDTH  = 8,
    parameter int unsigned STACK_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);

    logic                  clk_ph2_enable;
    logic [LOW_WIDTH-1:0]  ADL_in;
    logic [HIGH_WIDTH-1:0] ADH_in;
    logic                  ADL_in_en;
    logic                  ADH_in_en;
    logic                  INC_en;
    logic                  BR_en;
    logic [LOW_WIDTH-1:0]  BR_offset;
    logic                  SAVE_en;
    logic                  RESTORE_en;

    logic [LOW_WIDTH-1:0]  PCL_out;
    logic [HIGH_WIDTH-1:0] PCH_out;
    logic                  fixup_busy;
    logic [LVL_W-1:0]      stack_level;
    logic                  stack_full;
    logic                  stack_empty;
    logic                  stack_err;

    modport master (
        output clk_ph2_enable, ADL_in, ADH_in, ADL_in_en, ADH_in_en, INC_en,
               BR_en, BR_offset, SAVE_en, RESTORE_en,
        input  PCL_out, PCH_out, fixup_busy, stack_level, stack_full,
               stack_empty, stack_err
    );

    modport slave (
        input  clk_ph2_enable, ADL_in, ADH_in, ADL_in_en, ADH_in_en, INC_en,
               BR_en, BR_offset, SAVE_en, RESTORE_en,
        output PCL_out, PCH_out, fixup_busy, stack_level, stack_full,
               stack_empty, stack_err
    );
endinterface

// File: rtl/program_counter_ext.sv
// Program counter with split PCL/PCH load/increment, relative branch with
// page-cross fixup cycle, and a small LIFO of saved PC values.
module program_counter_ext #(
    parameter int unsigned                      LOW_WIDTH   = 8,
    parameter int unsigned                      HIGH_WIDTH  = 8,
    parameter logic [HIGH_WIDTH+LOW_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned                      STACK_DEPTH = 4
) (
    input  logic                  sys_clock,
    input  logic                  reset,
    program_counter_ext_if.slave  bus
);
    localparam int unsigned PC_W  = HIGH_WIDTH + LOW_WIDTH;
    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic {S_RUN, S_FIXUP} state_e;

    state_e                state_q, state_d;
    logic [LOW_WIDTH-1:0]  pcl_q, pcl_d;
    logic [HIGH_WIDTH-1:0] pch_q, pch_d;
    logic                  dir_up_q, dir_up_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  err_q, err_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  busy_q, busy_d;

    logic [PC_W-1:0]       stack_q [STACK_DEPTH];

    logic                  push_c;
    logic [IDX_W-1:0]      push_idx_c;
    logic [IDX_W-1:0]      top_idx_c;
    logic                  save_c, restore_c, conflict_c, cross_c;
    logic [LOW_WIDTH:0]    br_sum_c;
    logic [PC_W-1:0]       ld_pc_c, inc_pc_c;

    // Next-state decode for PC, FSM and stack bookkeeping
    always_comb begin
        state_d    = state_q;
        pcl_d      = pcl_q;
        pch_d      = pch_q;
        dir_up_d   = dir_up_q;
        level_d    = level_q;
        err_d      = 1'b0;
        busy_d     = 1'b0;
        push_c     = 1'b0;
        cross_c    = 1'b0;
        save_c     = bus.SAVE_en & ~bus.RESTORE_en;
        restore_c  = bus.RESTORE_en & ~bus.SAVE_en;
        conflict_c = bus.SAVE_en & bus.RESTORE_en;
        push_idx_c = IDX_W'(level_q);
        top_idx_c  = IDX_W'(level_q - LVL_W'(1));
        br_sum_c   = {1'b0, pcl_q} + {1'b0, bus.BR_offset};
        ld_pc_c    = {(bus.ADH_in_en ? bus.ADH_in : pch_q),
                      (bus.ADL_in_en ? bus.ADL_in : pcl_q)};
        inc_pc_c   = ld_pc_c + PC_W'(1);

        case (state_q)
            S_RUN: begin
                if (restore_c) begin
                    if (!empty_q) begin
                        {pch_d, pcl_d} = stack_q[top_idx_c];
                        level_d        = level_q - LVL_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    if (conflict_c) begin
                        err_d = 1'b1;
                    end else if (save_c) begin
                        if (full_q) begin
                            err_d = 1'b1;
                        end else begin
                            push_c  = 1'b1;
                            level_d = level_q + LVL_W'(1);
                        end
                    end

                    if (bus.BR_en) begin
                        // Crossing iff offset sign disagrees with the carry out of PCL
                        pcl_d    = br_sum_c[LOW_WIDTH-1:0];
                        cross_c  = bus.BR_offset[LOW_WIDTH-1] ^ br_sum_c[LOW_WIDTH];
                        dir_up_d = ~bus.BR_offset[LOW_WIDTH-1];
                        busy_d   = cross_c;
                        state_d  = cross_c ? S_FIXUP : S_RUN;
                    end else if (bus.INC_en) begin
                        {pch_d, pcl_d} = inc_pc_c;
                    end else begin
                        {pch_d, pcl_d} = ld_pc_c;
                    end
                end
            end
            S_FIXUP: begin
                pch_d   = dir_up_q ? pch_q + HIGH_WIDTH'(1) : pch_q - HIGH_WIDTH'(1);
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        full_d  = (level_d == LVL_W'(STACK_DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_RUN;
            pcl_q    <= RESET_PC[LOW_WIDTH-1:0];
            pch_q    <= RESET_PC[PC_W-1:LOW_WIDTH];
            dir_up_q <= 1'b0;
            level_q  <= '0;
            err_q    <= 1'b0;
            full_q   <= (STACK_DEPTH == 0);
            empty_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else if (bus.clk_ph2_enable) begin
            state_q  <= state_d;
            pcl_q    <= pcl_d;
            pch_q    <= pch_d;
            dir_up_q <= dir_up_d;
            level_q  <= level_d;
            err_q    <= err_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            busy_q   <= busy_d;
        end
    end

    // Stack storage carries no reset; validity is tracked by level_q
    always_ff @(posedge sys_clock) begin
        if (bus.clk_ph2_enable && push_c) begin
            stack_q[push_idx_c] <= {pch_q, pcl_q};
        end
    end

    assign bus.PCL_out     = pcl_q;
    assign bus.PCH_out     = pch_q;
    assign bus.fixup_busy  = busy_q;
    assign bus.stack_level = level_q;
    assign bus.stack_full  = full_q;
    assign bus.stack_empty = empty_q;
    assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_program_counter_ext.sv
// Directed vector bench for program_counter_ext: a table of per-edge commands
// with expected PC/stack state, plus hand sequences for reset and enable gating.
module tb_program_counter_ext;

    logic sys_clock = 1'b0;
    logic reset     = 1'b0;

    program_counter_ext_if #(.LOW_WIDTH(8), .HIGH_WIDTH(8), .STACK_DEPTH(4)) bus ();

    program_counter_ext #(
        .LOW_WIDTH(8), .HIGH_WIDTH(8), .RESET_PC(16'hFFFC), .STACK_DEPTH(4)
    ) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .bus       (bus.slave)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        logic [15:0] ld;
        logic        ld_en;
        logic        inc;
        logic        br;
        logic [7:0]  off;
        logic        sv;
        logic        rs;
        logic [15:0] pc;
        logic [2:0]  lvl;
        logic        err;
        logic        busy;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vq[$];

    function automatic vec_t mk(input logic [15:0] ld, input logic ld_en, input logic inc,
                                input logic br, input logic [7:0] off, input logic sv,
                                input logic rs, input logic [15:0] pc, input logic [2:0] lvl,
                                input logic err, input logic busy);
        vec_t v;
        v.ld = ld; v.ld_en = ld_en; v.inc = inc; v.br = br; v.off = off;
        v.sv = sv; v.rs = rs; v.pc = pc; v.lvl = lvl; v.err = err; v.busy = busy;
        return v;
    endfunction

    task automatic drive(input logic en, input logic [15:0] ld, input logic ld_en,
                         input logic inc, input logic br, input logic [7:0] off,
                         input logic sv, input logic rs);
        bus.clk_ph2_enable = en;
        bus.ADL_in         = ld[7:0];
        bus.ADH_in         = ld[15:8];
        bus.ADL_in_en      = ld_en;
        bus.ADH_in_en      = ld_en;
        bus.INC_en         = inc;
        bus.BR_en          = br;
        bus.BR_offset      = off;
        bus.SAVE_en        = sv;
        bus.RESTORE_en     = rs;
    endtask

    task automatic check(input string name, input logic [15:0] pc, input logic [2:0] lvl,
                         input logic err, input logic busy);
        logic [15:0] a_pc;
        logic        e_full, e_empty;
        a_pc    = {bus.PCH_out, bus.PCL_out};
        e_full  = (lvl == 3'd4);
        e_empty = (lvl == 3'd0);
        n_vec++;
        if (a_pc !== pc || bus.stack_level !== lvl || bus.stack_err !== err ||
            bus.fixup_busy !== busy || bus.stack_full !== e_full || bus.stack_empty !== e_empty) begin
            n_bad++;
            $display("FAIL %s: got pc=%h lvl=%0d err=%b busy=%b full=%b empty=%b, want pc=%h lvl=%0d err=%b busy=%b full=%b empty=%b",
                     name, a_pc, bus.stack_level, bus.stack_err, bus.fixup_busy,
                     bus.stack_full, bus.stack_empty, pc, lvl, err, busy, e_full, e_empty);
        end
    endtask

    task automatic step(input vec_t v, input string name);
        drive(1'b1, v.ld, v.ld_en, v.inc, v.br, v.off, v.sv, v.rs);
        @(posedge sys_clock);
        #1;
        check(name, v.pc, v.lvl, v.err, v.busy);
    endtask

    initial begin
        //        ld       ld_en inc br off    sv rs  pc       lvl err busy
        vq.push_back(mk(16'h12FF, 1, 0, 0, 8'h00, 0, 0, 16'h12FF, 0, 0, 0));
        vq.push_back(mk(16'h0000, 0, 1, 0, 8'h00, 0, 0, 16'h1300, 0, 0, 0));
        vq.push_back(mk(16'hFFFF, 1, 0, 0, 8'h00, 0, 0, 16'hFFFF, 0, 0, 0));
        vq.push_back(mk(16'h0000, 0, 1, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 0));
        vq.push_back(mk(16'h5634, 1, 1, 0, 8'h00, 0, 0, 16'h5635, 0, 0, 0));
        vq.push_back(mk(16'h10F0, 1, 0, 0, 8'h00, 0, 0, 16'h10F0, 0, 0, 0));
        vq.push_back(mk(16'h0000, 0, 0, 1, 8'h08, 0, 0, 16'h10F8, 0, 0, 0));
        vq.push_back(mk(16'h10F0, 1, 0, 0, 8'h00, 0, 0, 16'h10F0, 0, 0, 0));
        vq.push_back(mk(16'h0000, 0, 0, 1, 8'h20, 0, 0, 16'h1010, 0, 0, 1));
        vq.push_back(mk(16'h0000, 0, 0, 0, 8'h00, 0, 0, 16'h1110, 0, 0, 0));
        vq.push_back(mk(16'h1005, 1, 0, 0, 8'h00, 0, 0, 16'h1005, 0, 0, 0));
        vq.push_back(mk(16'h0000, 0, 0, 1, 8'hF0, 0, 0, 16'h10F5, 0, 0, 1));
        vq.push_back(mk(16'h0000, 0, 0, 0, 8'h00, 0, 0, 16'h0FF5, 0, 0, 0));
        vq.push_back(mk(16'h00F0, 1, 0, 0, 8'h00, 0, 0, 16'h00F0, 0, 0, 0));
        vq.push_back(mk(16'h0000, 0, 0, 1, 8'h20, 0, 0, 16'h0010, 0, 0, 1));
        vq.push_back(mk(16'h0000, 0, 0, 0, 8'h00, 0, 0, 16'h0110, 0, 0, 0));
        vq.push_back(mk(16'h0005, 1, 0, 0, 8'h00, 0, 0, 16'h0005, 0, 0, 0));
        vq.push_back(mk(16'h0000, 0, 0, 1, 8'hF0, 0, 0, 16'h00F5, 0, 0, 1));
        vq.push_back(mk(16'h0000, 0, 0, 0, 8'h00, 0, 0, 16'hFFF5, 0, 0, 0));
        vq.push_back(mk(16'h2000, 1, 0, 0, 8'h00, 0, 0, 16'h2000, 0, 0, 0));
        vq.push_back(mk(16'h0000, 0, 1, 0, 8'h00, 1, 0, 16'h2001, 1, 0, 0));
        vq.push_back(mk(16'h3000, 1, 0, 0, 8'h00, 0, 0, 16'h3000, 1, 0, 0));
        vq.push_back(mk(16'h0000, 0, 0, 0, 8'h00, 0, 1, 16'h2000, 0, 0, 0));
        vq.push_back(mk(16'h7777, 1, 1, 1, 8'h10, 0, 1, 16'h2000, 0, 1, 0));
        vq.push_back(mk(16'h0000, 0, 0, 0, 8'h00, 0, 0, 16'h2000, 0, 0, 0));
        // fill A..D, overflow on the fifth save, then drain LIFO
        vq.push_back(mk(16'h1111, 1, 0, 0, 8'h00, 0, 0, 16'h1111, 0, 0, 0));
        vq.push_back(mk(16'h2222, 1, 0, 0, 8'h00, 1, 0, 16'h2222, 1, 0, 0));
        vq.push_back(mk(16'h3333, 1, 0, 0, 8'h00, 1, 0, 16'h3333, 2, 0, 0));
        vq.push_back(mk(16'h4444, 1, 0, 0, 8'h00, 1, 0, 16'h4444, 3, 0, 0));
        vq.push_back(mk(16'h5555, 1, 0, 0, 8'h00, 1, 0, 16'h5555, 4, 0, 0));
        vq.push_back(mk(16'h6666, 1, 0, 0, 8'h00, 1, 0, 16'h6666, 4, 1, 0));
        vq.push_back(mk(16'h0000, 0, 0, 0, 8'h00, 0, 1, 16'h4444, 3, 0, 0));
        vq.push_back(mk(16'h0000, 0, 0, 0, 8'h00, 0, 1, 16'h3333, 2, 0, 0));
        vq.push_back(mk(16'h0000, 0, 0, 0, 8'h00, 0, 1, 16'h2222, 1, 0, 0));
        vq.push_back(mk(16'h0000, 0, 0, 0, 8'h00, 0, 1, 16'h1111, 0, 0, 0));

        drive(1'b0, 16'h0000, 0, 0, 0, 8'h00, 0, 0);
        #12;
        check("reset_state", 16'hFFFC, 0, 0, 0);
        @(negedge sys_clock);
        reset = 1'b1;
        @(posedge sys_clock);
        #1;

        foreach (vq[i]) step(vq[i], $sformatf("vec%0d", i));

        // Underflow error, then gated edges must hold everything including stack_err
        step(mk(16'h0000, 0, 0, 0, 8'h00, 0, 1, 16'h1111, 0, 1, 0), "underflow_err");
        drive(1'b0, 16'hABCD, 1, 1, 1, 8'h40, 1, 1);
        repeat (3) @(posedge sys_clock);
        #1;
        check("ph2_gated_hold", 16'h1111, 0, 1, 0);
        step(mk(16'h0000, 0, 0, 0, 8'h00, 0, 0, 16'h1111, 0, 0, 0), "err_clears");
        step(mk(16'h0000, 0, 0, 0, 8'h00, 1, 0, 16'h1111, 1, 0, 0), "save_one");
        step(mk(16'h0000, 0, 1, 0, 8'h00, 1, 1, 16'h1112, 1, 1, 0), "save_restore_conflict");
        step(mk(16'h0000, 0, 0, 0, 8'h00, 0, 1, 16'h1111, 0, 0, 0), "restore_after_conflict");

        // Async reset while in FIXUP
        step(mk(16'h40F0, 1, 0, 0, 8'h00, 0, 0, 16'h40F0, 0, 0, 0), "pre_fixup_load");
        step(mk(16'h0000, 0, 0, 1, 8'h20, 1, 0, 16'h4010, 1, 0, 1), "enter_fixup");
        drive(1'b1, 16'h0000, 0, 0, 0, 8'h00, 0, 0);
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_mid_fixup", 16'hFFFC, 0, 0, 0);
        @(posedge sys_clock);
        #1;
        check("reset_holds", 16'hFFFC, 0, 0, 0);
        reset = 1'b1;
        step(mk(16'h0000, 0, 1, 0, 8'h00, 0, 0, 16'hFFFD, 0, 0, 0), "run_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/program_counter_ext.md
Name: program_counter_ext

Overview:
- Parametrised next-generation program counter for the CPU core. It keeps the split PCL/PCH load and increment datapath on the phase-2 enable.
- Adds a signed relative branch adder with a 6502-style page-cross fixup cycle.
- Adds a small hardware save/restore stack of PC values for interrupt entry and return.
- Sits between the address-bus drivers (ADL/ADH) and the PC bus consumed by the address mux and internal buses.

Parameters:
- LOW_WIDTH, 8, width of PCL, ADL_in and BR_offset.
- HIGH_WIDTH, 8, width of PCH and ADH_in.
- RESET_PC, 16'h0000, PC value on reset. {PCH,PCL} is taken from RESET_PC[HIGH_WIDTH+LOW_WIDTH-1:0].
- STACK_DEPTH, 4, number of PC save entries. Legal range is 1..16.

Ports:
- sys_clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- clk_ph2_enable  input  1  phase-2 enable. State advances only on edges where it is 1.
- ADL_in  input  LOW_WIDTH  address bus low value.
- ADH_in  input  HIGH_WIDTH  address bus high value.
- ADL_in_en  input  1  load PCL from ADL_in.
- ADH_in_en  input  1  load PCH from ADH_in.
- INC_en  input  1  increment the selected PC.
- BR_en  input  1  take relative branch.
- BR_offset  input  LOW_WIDTH  two's-complement branch offset.
- SAVE_en  input  1  push the current PC onto the save stack.
- RESTORE_en  input  1  pop the save stack into the PC.
- PCL_out  output  LOW_WIDTH  registered PC low.
- PCH_out  output  HIGH_WIDTH  registered PC high.
- fixup_busy  output  1  high while in the FIXUP state.
- stack_level  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
- stack_full  output  1  stack_level == STACK_DEPTH.
- stack_empty  output  1  stack_level == 0.
- stack_err  output  1  one-enabled-cycle pulse on overflow, underflow or save/restore conflict.

Behaviour:
- Reset (asynchronous, reset == 0):
  - {PCH,PCL} = RESET_PC, state = RUN, stack_level = 0, stack_err = 0, fixup_busy = 0.
  - Reset mid-fixup abandons the fixup.
- All outputs are registered; the updated PC is visible after the enabled edge.
- When clk_ph2_enable == 0, all state holds, including stack_err.
- RUN state, per enabled edge, commands are applied in priority order:
  1. RESTORE_en (without SAVE_en):
     - If stack not empty: PC <= top entry, stack_level decrements.
     - If empty: PC holds and stack_err pulses.
     - ADx_in_en, INC_en and BR_en are ignored this cycle.
  2. BR_en:
     - sum = {0,PCL} + BR_offset (LOW_WIDTH+1 bits); PCL <= sum[LOW_WIDTH-1:0].
     - Page cross occurs when offset MSB = 0 and carry = 1 (crossing up), or offset MSB = 1 and carry = 0 (crossing down).
     - On a cross: state <= FIXUP with the direction latched; PCH unchanged this cycle.
     - Offset 0 never crosses.
     - ADx_in_en and INC_en are ignored.
  3. Otherwise, load/increment:
     - PCLS = ADL_in_en ? ADL_in : PCL; PCHS = ADH_in_en ? ADH_in : PCH.
     - If INC_en: {PCH,PCL} <= {PCHS,PCLS} + 1 with the carry out of PCL into PCH. The increment wraps modulo 2^(HIGH_WIDTH+LOW_WIDTH), so all-ones goes to 0.
     - Else: {PCH,PCL} <= {PCHS,PCLS}.
- SAVE_en (without RESTORE_en) combines with items 2 and 3:
  - It pushes the pre-edge {PCH,PCL}.
  - If the stack is full: no push and stack_err pulses; the PC operation still executes.
- SAVE_en and RESTORE_en together: no stack change, stack_err pulses, and the PC follows items 2/3.
- FIXUP state (one enabled cycle):
  - PCH <= PCH + 1 if crossing up, PCH - 1 if crossing down, modulo 2^HIGH_WIDTH; PCL holds; state <= RUN.
  - All command inputs are ignored, including SAVE_en and RESTORE_en; the bench must hold them low.
  - fixup_busy = 1 for the whole FIXUP state.
- The stack is LIFO: the top entry is the most recently pushed one.
- stack_err is asserted for exactly one enabled cycle after the faulting edge, then clears on the next enabled edge.

Test Plan:
- Reset with RESET_PC = 16'hFFFC, reset low asynchronously mid-cycle -> PC = FFFC immediately, stack_empty = 1, fixup_busy = 0.
- PC = 12FF, INC_en -> 1300. PC = FFFF, INC_en -> 0000. ADL = 34, ADH = 56 with both enables and INC_en -> 5635.
- Branches:
  - PC = 10F0, BR_offset = 08 -> 10F8, no fixup.
  - PC = 10F0, BR_offset = 20 -> PCL = 10 then fixup -> 1110, fixup_busy high for 1 enabled cycle.
  - PC = 1005, BR_offset = F0 -> PCL = F5 then 0FF5.
  - PC = 00F0, BR_offset = 20 -> 0010 then fixup -> 0110 (PCH 00+1; the up-direction fixup incrementing PCH from 00).
  - PC = 0005, BR_offset = F0 -> PCL = F5, then fixup -> FFF5 (PCH 00-1 wraps to FF).
- Save/restore:
  - PC = 2000, SAVE_en+INC_en -> PC 2001, level 1.
  - Then load 3000, then RESTORE_en -> PC 2000, level 0.
  - RESTORE_en when empty -> PC holds, stack_err one pulse.
- Fill the stack with 4 saves (A,B,C,D), then a 5th save -> stack_err, level stays 4. Four restores return D, C, B, A.
- clk_ph2_enable held 0 with all commands active -> no state change. SAVE_en+RESTORE_en together -> stack_err, level unchanged, INC_en still applied.
